// File: rtl/csr_file.sv
// csr_file: EX-stage CSR read-modify-write with 64-bit cycle/instret counters
// and the vector CSRs vstart, vl and vtype. Reads are combinational (old value).
module csr_file #(
  parameter logic [31:0] MSCRATCH_RST = 32'h0,
  parameter logic [31:0] VTYPE_RST    = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        csr_en,
  input  logic        stall,
  input  logic [11:0] csr_addr,
  input  logic [3:0]  ALUOp,
  input  logic        csr_immidiate,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  rs1_zimm,
  input  logic        instr_retire,
  input  logic        vset_we,
  input  logic [31:0] vset_vl,
  input  logic [31:0] vset_vtype,
  output logic [31:0] csr_rdata,
  output logic        illegal_csr,
  output logic [31:0] vl_out,
  output logic [31:0] vtype_out,
  output logic [31:0] vstart_out
);

  // ALU control decode encodings for CSR instructions
  localparam logic [3:0] ALU_PASS  = 4'd10;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_CLEAR = 4'd11;

  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_VSTART    = 12'h008;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_VL        = 12'hC20;
  localparam logic [11:0] A_VTYPE     = 12'hC21;
  localparam logic [11:0] A_VLENB     = 12'hC22;

  localparam logic [31:0] VLENB_VAL = 32'd16;

  logic [31:0] mscratch;
  logic [31:0] vstart;
  logic [31:0] vl;
  logic [31:0] vtype;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  logic [31:0] old_val;
  logic [31:0] new_val;
  logic [31:0] op;
  logic        implemented;
  logic        is_ro;
  logic        wint;
  logic        wr;
  logic        wr_mscratch, wr_vstart;
  logic        wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

  always_comb begin
    old_val     = 32'h0;
    implemented = 1'b1;
    is_ro       = 1'b0;
    case (csr_addr)
      A_MSCRATCH:  old_val = mscratch;
      A_VSTART:    old_val = vstart;
      A_MCYCLE:    old_val = mcycle[31:0];
      A_MCYCLEH:   old_val = mcycle[63:32];
      A_MINSTRET:  old_val = minstret[31:0];
      A_MINSTRETH: old_val = minstret[63:32];
      A_CYCLE:     begin old_val = mcycle[31:0];    is_ro = 1'b1; end
      A_CYCLEH:    begin old_val = mcycle[63:32];   is_ro = 1'b1; end
      A_INSTRET:   begin old_val = minstret[31:0];  is_ro = 1'b1; end
      A_INSTRETH:  begin old_val = minstret[63:32]; is_ro = 1'b1; end
      A_VL:        begin old_val = vl;              is_ro = 1'b1; end
      A_VTYPE:     begin old_val = vtype;           is_ro = 1'b1; end
      A_VLENB:     begin old_val = VLENB_VAL;       is_ro = 1'b1; end
      default:     implemented = 1'b0;
    endcase
  end

  assign op = csr_immidiate ? {27'b0, rs1_zimm} : rs1_data;

  // Set/clear with rs1 = x0 (or zimm = 0) is a pure read and never faults on RO CSRs
  always_comb begin
    new_val = old_val;
    wint    = 1'b0;
    case (ALUOp)
      ALU_PASS:  begin new_val = op;               wint = 1'b1; end
      ALU_OR:    begin new_val = old_val | op;     wint = (rs1_zimm != 5'd0); end
      ALU_CLEAR: begin new_val = old_val & ~op;    wint = (rs1_zimm != 5'd0); end
      default:   ;
    endcase
  end

  assign wr           = csr_en & ~stall & wint & implemented & ~is_ro;
  assign wr_mscratch  = wr & (csr_addr == A_MSCRATCH);
  assign wr_vstart    = wr & (csr_addr == A_VSTART);
  assign wr_mcycle    = wr & (csr_addr == A_MCYCLE);
  assign wr_mcycleh   = wr & (csr_addr == A_MCYCLEH);
  assign wr_minstret  = wr & (csr_addr == A_MINSTRET);
  assign wr_minstreth = wr & (csr_addr == A_MINSTRETH);

  assign csr_rdata   = old_val;
  assign illegal_csr = csr_en & (~implemented | (wint & is_ro));
  assign vl_out      = vl;
  assign vtype_out   = vtype;
  assign vstart_out  = vstart;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mscratch <= MSCRATCH_RST;
      vstart   <= 32'h0;
      vl       <= 32'h0;
      vtype    <= VTYPE_RST;
      mcycle   <= 64'h0;
      minstret <= 64'h0;
    end else begin
      if (wr_mscratch) mscratch <= new_val;

      if (vset_we) begin
        vl     <= vset_vl;
        vtype  <= vset_vtype;
        vstart <= 32'h0;
      end else if (wr_vstart) begin
        vstart <= new_val;
      end

      // A write to either half suppresses that counter's increment for the cycle
      if (wr_mcycle)       mcycle[31:0]  <= new_val;
      else if (wr_mcycleh) mcycle[63:32] <= new_val;
      else                 mcycle        <= mcycle + 64'd1;

      if (wr_minstret)                minstret[31:0]  <= new_val;
      else if (wr_minstreth)          minstret[63:32] <= new_val;
      else if (instr_retire & ~stall) minstret        <= minstret + 64'd1;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus randomized traffic
// checked against an address-map reference model.
module tb_csr_file;

  localparam logic [3:0] PASS  = 4'd10;
  localparam logic [3:0] OR_OP = 4'd1;
  localparam logic [3:0] CLR   = 4'd11;
  localparam logic [3:0] OTHER = 4'd0;

  logic        clock;
  logic        reset;
  logic        csr_en;
  logic        stall;
  logic [11:0] csr_addr;
  logic [3:0]  ALUOp;
  logic        csr_immidiate;
  logic [31:0] rs1_data;
  logic [4:0]  rs1_zimm;
  logic        instr_retire;
  logic        vset_we;
  logic [31:0] vset_vl;
  logic [31:0] vset_vtype;
  logic [31:0] csr_rdata;
  logic        illegal_csr;
  logic [31:0] vl_out;
  logic [31:0] vtype_out;
  logic [31:0] vstart_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] m_cyc, m_ins;
  logic [31:0] m_scr, m_vst, m_vl, m_vty;

  csr_file dut (
    .clock(clock), .reset(reset), .csr_en(csr_en), .stall(stall),
    .csr_addr(csr_addr), .ALUOp(ALUOp), .csr_immidiate(csr_immidiate),
    .rs1_data(rs1_data), .rs1_zimm(rs1_zimm), .instr_retire(instr_retire),
    .vset_we(vset_we), .vset_vl(vset_vl), .vset_vtype(vset_vtype),
    .csr_rdata(csr_rdata), .illegal_csr(illegal_csr), .vl_out(vl_out),
    .vtype_out(vtype_out), .vstart_out(vstart_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic bit is_rw(input logic [11:0] a);
    return a inside {12'h340, 12'h008, 12'hB00, 12'hB80, 12'hB02, 12'hB82};
  endfunction

  function automatic bit is_ro(input logic [11:0] a);
    return a inside {12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hC20, 12'hC21, 12'hC22};
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h340:          return m_scr;
      12'h008:          return m_vst;
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
      12'hC20:          return m_vl;
      12'hC21:          return m_vty;
      12'hC22:          return 32'd16;
      default:          return 32'h0;
    endcase
  endfunction

  function automatic bit m_wint();
    return (ALUOp == PASS) || ((ALUOp == OR_OP || ALUOp == CLR) && rs1_zimm != 5'd0);
  endfunction

  function automatic bit m_illegal();
    return csr_en && (!(is_rw(csr_addr) || is_ro(csr_addr)) || (m_wint() && is_ro(csr_addr)));
  endfunction

  task automatic model_reset();
    m_cyc = 64'h0; m_ins = 64'h0; m_scr = 32'h0;
    m_vst = 32'h0; m_vl = 32'h0;  m_vty = 32'h8000_0000;
  endtask

  // Predict the state after the coming rising edge, then step past it
  task automatic advance();
    logic [31:0] op, old, nv, ns, nvs, nvl, nvt;
    logic [63:0] nc, ni;
    bit wr;
    op  = csr_immidiate ? {27'b0, rs1_zimm} : rs1_data;
    old = m_read(csr_addr);
    if (ALUOp == PASS)       nv = op;
    else if (ALUOp == OR_OP) nv = old | op;
    else if (ALUOp == CLR)   nv = old & ~op;
    else                     nv = old;
    wr  = csr_en && !stall && m_wint() && is_rw(csr_addr);
    nc  = m_cyc + 64'd1;
    ni  = (instr_retire && !stall) ? m_ins + 64'd1 : m_ins;
    ns = m_scr; nvs = m_vst; nvl = m_vl; nvt = m_vty;
    if (wr) begin
      case (csr_addr)
        12'h340: ns  = nv;
        12'h008: nvs = nv;
        12'hB00: nc  = {m_cyc[63:32], nv};
        12'hB80: nc  = {nv, m_cyc[31:0]};
        12'hB02: ni  = {m_ins[63:32], nv};
        12'hB82: ni  = {nv, m_ins[31:0]};
        default: ;
      endcase
    end
    if (vset_we) begin nvl = vset_vl; nvt = vset_vtype; nvs = 32'h0; end
    @(posedge clock); #1;
    m_cyc = nc; m_ins = ni; m_scr = ns; m_vst = nvs; m_vl = nvl; m_vty = nvt;
  endtask

  task automatic idle();
    csr_en = 1'b0; stall = 1'b0; csr_addr = 12'h0; ALUOp = OTHER;
    csr_immidiate = 1'b0; rs1_data = 32'h0; rs1_zimm = 5'd0;
    instr_retire = 1'b0; vset_we = 1'b0; vset_vl = 32'h0; vset_vtype = 32'h0;
  endtask

  task automatic set_op(input logic [3:0] op, input logic imm, input logic [11:0] a,
                        input logic [31:0] rs1, input logic [4:0] zimm);
    csr_en = 1'b1; ALUOp = op; csr_immidiate = imm; csr_addr = a;
    rs1_data = rs1; rs1_zimm = zimm;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #1;
    n_cmp++; if (vl_out !== 32'h0) begin n_bad++; $display("FAIL rst_vl got=%h exp=%h", vl_out, 32'h0); end
    n_cmp++; if (vtype_out !== 32'h8000_0000) begin n_bad++; $display("FAIL rst_vtype got=%h exp=%h", vtype_out, 32'h8000_0000); end
    n_cmp++; if (vstart_out !== 32'h0) begin n_bad++; $display("FAIL rst_vstart got=%h exp=%h", vstart_out, 32'h0); end
    csr_addr = 12'h340;
    #1;
    n_cmp++; if (csr_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_mscratch got=%h exp=%h", csr_rdata, 32'h0); end
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    csr_addr = 12'hC00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_cmp++; if (csr_rdata !== 32'(i)) begin n_bad++; $display("FAIL cycle_count[%0d] got=%0d exp=%0d", i, csr_rdata, i); end
      n_cmp++; if (illegal_csr !== 1'b0) begin n_bad++; $display("FAIL rst_illegal[%0d] got=%b exp=0", i, illegal_csr); end
      advance();
    end
    csr_addr = 12'hC21;
    @(negedge clock);
    n_cmp++; if (csr_rdata !== 32'h8000_0000) begin n_bad++; $display("FAIL rd_vtype got=%h exp=%h", csr_rdata, 32'h8000_0000); end
    advance();
  endtask

  task automatic test_mscratch();
    set_op(PASS, 1'b0, 12'h340, 32'hDEAD_BEEF, 5'd7);
    @(negedge clock);
    n_cmp++; if (csr_rdata !== 32'h0) begin n_bad++; $display("FAIL csrrw_old got=%h exp=%h", csr_rdata, 32'h0); end
    advance();
    set_op(OR_OP, 1'b0, 12'h340, 32'h0, 5'd0);
    @(negedge clock);
    n_cmp++; if (csr_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL csrrs_x0 got=%h exp=%h", csr_rdata, 32'hDEAD_BEEF); end
    n_cmp++; if (illegal_csr !== 1'b0) begin n_bad++; $display("FAIL csrrs_x0_illegal got=%b exp=0", illegal_csr); end
    advance();
    idle(); csr_addr = 12'h340;
    @(negedge clock);
    n_cmp++; if (csr_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL csrrs_nowrite got=%h exp=%h", csr_rdata, 32'hDEAD_BEEF); end
    advance();
  endtask

  task automatic test_imm();
    set_op(PASS, 1'b0, 12'h340, 32'h0000_00F0, 5'd3);
    @(negedge clock); advance();
    set_op(OR_OP, 1'b1, 12'h340, 32'hFFFF_0000, 5'd5);
    @(negedge clock);
    n_cmp++; if (csr_rdata !== 32'hF0) begin n_bad++; $display("FAIL csrrsi_old got=%h exp=%h", csr_rdata, 32'hF0); end
    advance();
    set_op(CLR, 1'b1, 12'h340, 32'hFFFF_FFFF, 5'd1);
    @(negedge clock);
    n_cmp++; if (csr_rdata !== 32'hF5) begin n_bad++; $display("FAIL csrrci_old got=%h exp=%h", csr_rdata, 32'hF5); end
    advance();
    idle(); csr_addr = 12'h340;
    @(negedge clock);
    n_cmp++; if (csr_rdata !== 32'hF4) begin n_bad++; $display("FAIL csrrci_new got=%h exp=%h", csr_rdata, 32'hF4); end
    advance();
  endtask

  task automatic test_counter_carry();
    set_op(PASS, 1'b0, 12'hB80, 32'h0, 5'd1);
    @(negedge clock); advance();
    set_op(PASS, 1'b0, 12'hB00, 32'hFFFF_FFFF, 5'd1);
    @(negedge clock); advance();
    idle(); csr_addr = 12'hB00;
    @(negedge clock);
    n_cmp++; if (csr_rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mcycle_wr got=%h exp=%h", csr_rdata, 32'hFFFF_FFFF); end
    advance();
    @(negedge clock);
    n_cmp++; if (csr_rdata !== 32'h0) begin n_bad++; $display("FAIL mcycle_wrap got=%h exp=%h", csr_rdata, 32'h0); end
    csr_addr = 12'hB80; #1;
    n_cmp++; if (csr_rdata !== 32'h1) begin n_bad++; $display("FAIL mcycleh_carry got=%h exp=%h", csr_rdata, 32'h1); end
    csr_addr = 12'hC80; #1;
    n_cmp++; if (csr_rdata !== 32'h1) begin n_bad++; $display("FAIL cycleh_alias got=%h exp=%h", csr_rdata, 32'h1); end
    advance();
  endtask

  task automatic test_vset();
    set_op(PASS, 1'b0, 12'h008, 32'h7, 5'd2);
    @(negedge clock); advance();
    n_cmp++; if (vstart_out !== 32'h7) begin n_bad++; $display("FAIL vstart_wr got=%h exp=%h", vstart_out, 32'h7); end
    set_op(PASS, 1'b0, 12'h008, 32'h3, 5'd2);
    vset_we = 1'b1; vset_vl = 32'd8; vset_vtype = 32'h0D;
    @(negedge clock); advance();
    idle();
    n_cmp++; if (vl_out !== 32'd8) begin n_bad++; $display("FAIL vset_vl got=%h exp=%h", vl_out, 32'd8); end
    n_cmp++; if (vtype_out !== 32'h0D) begin n_bad++; $display("FAIL vset_vtype got=%h exp=%h", vtype_out, 32'h0D); end
    n_cmp++; if (vstart_out !== 32'h0) begin n_bad++; $display("FAIL vset_vstart got=%h exp=%h", vstart_out, 32'h0); end
  endtask

  task automatic test_ro_illegal();
    set_op(PASS, 1'b0, 12'hC20, 32'h55, 5'd4);
    @(negedge clock);
    n_cmp++; if (illegal_csr !== 1'b1) begin n_bad++; $display("FAIL ro_write_illegal got=%b exp=1", illegal_csr); end
    advance();
    n_cmp++; if (vl_out !== 32'd8) begin n_bad++; $display("FAIL ro_write_vl got=%h exp=%h", vl_out, 32'd8); end
    set_op(OR_OP, 1'b0, 12'hC20, 32'h0, 5'd0);
    @(negedge clock);
    n_cmp++; if (illegal_csr !== 1'b0) begin n_bad++; $display("FAIL ro_read_illegal got=%b exp=0", illegal_csr); end
    n_cmp++; if (csr_rdata !== 32'd8) begin n_bad++; $display("FAIL ro_read_vl got=%h exp=%h", csr_rdata, 32'd8); end
    set_op(CLR, 1'b1, 12'hC22, 32'hFFFF_FFFF, 5'd0); #1;
    n_cmp++; if (illegal_csr !== 1'b0) begin n_bad++; $display("FAIL vlenb_illegal got=%b exp=0", illegal_csr); end
    n_cmp++; if (csr_rdata !== 32'd16) begin n_bad++; $display("FAIL vlenb got=%h exp=%h", csr_rdata, 32'd16); end
    set_op(CLR, 1'b1, 12'hC00, 32'h0, 5'd2); #1;
    n_cmp++; if (illegal_csr !== 1'b1) begin n_bad++; $display("FAIL ro_clear_illegal got=%b exp=1", illegal_csr); end
    set_op(PASS, 1'b0, 12'h7FF, 32'h1234, 5'd1); #1;
    n_cmp++; if (illegal_csr !== 1'b1) begin n_bad++; $display("FAIL unimpl_illegal got=%b exp=1", illegal_csr); end
    n_cmp++; if (csr_rdata !== 32'h0) begin n_bad++; $display("FAIL unimpl_rdata got=%h exp=%h", csr_rdata, 32'h0); end
    csr_en = 1'b0; #1;
    n_cmp++; if (illegal_csr !== 1'b0) begin n_bad++; $display("FAIL unimpl_noen got=%b exp=0", illegal_csr); end
    advance();
  endtask

  task automatic test_stall();
    set_op(PASS, 1'b0, 12'h340, 32'h1234_5678, 5'd9);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_cmp++; if (csr_rdata !== 32'hF4) begin n_bad++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, csr_rdata, 32'hF4); end
      advance();
    end
    stall = 1'b0;
    @(negedge clock);
    n_cmp++; if (csr_rdata !== 32'hF4) begin n_bad++; $display("FAIL stall_release_old got=%h exp=%h", csr_rdata, 32'hF4); end
    advance();
    idle(); csr_addr = 12'h340;
    @(negedge clock);
    n_cmp++; if (csr_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL stall_commit got=%h exp=%h", csr_rdata, 32'h1234_5678); end
    advance();
  endtask

  task automatic test_reset_mid();
    set_op(PASS, 1'b0, 12'h340, 32'hAAAA_5555, 5'd1);
    vset_we = 1'b1; vset_vl = 32'd3; vset_vtype = 32'h11;
    @(negedge clock); #2;
    reset = 1'b1; #1;
    n_cmp++; if (vl_out !== 32'h0) begin n_bad++; $display("FAIL midrst_vl got=%h exp=%h", vl_out, 32'h0); end
    n_cmp++; if (vtype_out !== 32'h8000_0000) begin n_bad++; $display("FAIL midrst_vtype got=%h exp=%h", vtype_out, 32'h8000_0000); end
    n_cmp++; if (csr_rdata !== 32'h0) begin n_bad++; $display("FAIL midrst_mscratch got=%h exp=%h", csr_rdata, 32'h0); end
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    idle(); csr_addr = 12'h340;
    @(negedge clock);
    n_cmp++; if (csr_rdata !== 32'h0) begin n_bad++; $display("FAIL midrst_discard got=%h exp=%h", csr_rdata, 32'h0); end
    csr_addr = 12'hC00; #1;
    n_cmp++; if (csr_rdata !== 32'h0) begin n_bad++; $display("FAIL midrst_cycle got=%h exp=%h", csr_rdata, 32'h0); end
    advance();
  endtask

  task automatic test_random();
    logic [11:0] addrs [15];
    logic [3:0]  ops [4];
    addrs = '{12'h340, 12'h008, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
              12'hC80, 12'hC02, 12'hC82, 12'hC20, 12'hC21, 12'hC22, 12'h7FF, 12'h341};
    ops = '{PASS, OR_OP, CLR, OTHER};
    for (int i = 0; i < 400; i++) begin
      csr_en        = ($urandom_range(0, 3) != 0);
      stall         = ($urandom_range(0, 3) == 0);
      csr_addr      = addrs[$urandom_range(0, 14)];
      ALUOp         = ops[$urandom_range(0, 3)];
      csr_immidiate = 1'($urandom_range(0, 1));
      rs1_data      = $urandom();
      rs1_zimm      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      instr_retire  = 1'($urandom_range(0, 1));
      vset_we       = ($urandom_range(0, 9) == 0);
      vset_vl       = $urandom();
      vset_vtype    = $urandom();
      @(negedge clock);
      n_cmp++; if (csr_rdata !== m_read(csr_addr)) begin n_bad++; $display("FAIL rnd_rdata[%0d] addr=%h got=%h exp=%h", i, csr_addr, csr_rdata, m_read(csr_addr)); end
      n_cmp++; if (illegal_csr !== m_illegal()) begin n_bad++; $display("FAIL rnd_illegal[%0d] addr=%h got=%b exp=%b", i, csr_addr, illegal_csr, m_illegal()); end
      advance();
      n_cmp++; if (vl_out !== m_vl) begin n_bad++; $display("FAIL rnd_vl[%0d] got=%h exp=%h", i, vl_out, m_vl); end
      n_cmp++; if (vtype_out !== m_vty) begin n_bad++; $display("FAIL rnd_vtype[%0d] got=%h exp=%h", i, vtype_out, m_vty); end
      n_cmp++; if (vstart_out !== m_vst) begin n_bad++; $display("FAIL rnd_vstart[%0d] got=%h exp=%h", i, vstart_out, m_vst); end
    end
    idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    model_reset();
    test_reset();
    test_mscratch();
    test_imm();
    test_counter_carry();
    test_vset();
    test_ro_illegal();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
